// File: rtl/gomoku_pkg.sv
// Shared constants and FSM encoding for the Gomoku AI move controller.
package gomoku_pkg;
    localparam int BOARD_SIZE = 15;
    localparam int SCORE_W    = 13;
    localparam int COORD_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        SCAN,
        DECIDE,
        DONE
    } state_t;
endpackage

// File: rtl/gomoku_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, synchronous active-low reset.
module gomoku_lfsr
    import gomoku_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);
    logic feedback;

    assign feedback = out[15] ^ out[13] ^ out[12] ^ out[10];

    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= seed;
        end else begin
            out <= {out[14:0], feedback};
        end
    end
endmodule

// File: rtl/gomoku_ai_ctrl.sv
// Sequences the strategy block through clear/arm/full-board scan, then picks attack or block.
module gomoku_ai_ctrl #(
    parameter int                                BOARD_SIZE  = gomoku_pkg::BOARD_SIZE,
    parameter logic [15:0]                       LFSR_SEED   = 16'hACE1,
    parameter logic [gomoku_pkg::SCORE_W-1:0]    ATTACK_BIAS = 13'd0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               ai_is_black,
    input  logic [gomoku_pkg::SCORE_W-1:0]     black_best_score,
    input  logic [gomoku_pkg::COORD_W-1:0]     black_best_y,
    input  logic [gomoku_pkg::COORD_W-1:0]     black_best_x,
    input  logic [gomoku_pkg::SCORE_W-1:0]     white_best_score,
    input  logic [gomoku_pkg::COORD_W-1:0]     white_best_y,
    input  logic [gomoku_pkg::COORD_W-1:0]     white_best_x,
    output logic                               strat_clr,
    output logic                               strat_active,
    output logic                               strat_random,
    output logic                               busy,
    output logic                               move_valid,
    output logic [gomoku_pkg::COORD_W-1:0]     move_y,
    output logic [gomoku_pkg::COORD_W-1:0]     move_x,
    output logic                               move_attack
);
    import gomoku_pkg::*;

    localparam logic [7:0]         SCAN_LAST = 8'(BOARD_SIZE * BOARD_SIZE - 1);
    localparam logic [COORD_W-1:0] MID       = COORD_W'(BOARD_SIZE / 2);

    state_t               state;
    state_t               next_state;
    logic [7:0]           scan_cnt;
    logic                 ai_black;
    logic                 nxt_clr;
    logic                 nxt_active;
    logic                 nxt_busy;
    logic                 nxt_valid;
    logic [15:0]          lfsr_q;
    logic [14:0]          lfsr_unused;
    logic [SCORE_W-1:0]   own_score;
    logic [SCORE_W-1:0]   opp_score;
    logic [COORD_W-1:0]   own_y;
    logic [COORD_W-1:0]   own_x;
    logic [COORD_W-1:0]   opp_y;
    logic [COORD_W-1:0]   opp_x;
    logic [SCORE_W:0]     own_biased;
    logic                 attack;

    gomoku_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr_q)
    );

    assign {lfsr_unused, strat_random} = lfsr_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = ARM;
            ARM:     next_state = SCAN;
            SCAN:    if (scan_cnt == SCAN_LAST) next_state = DECIDE;
            DECIDE:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        nxt_clr    = 1'b0;
        nxt_active = 1'b0;
        nxt_busy   = 1'b1;
        nxt_valid  = 1'b0;
        case (next_state)
            IDLE: begin
                nxt_active = 1'b1;
                nxt_busy   = 1'b0;
            end
            CLEAR:        nxt_clr    = 1'b1;
            SCAN, DECIDE: nxt_active = 1'b1;
            DONE:         nxt_valid  = 1'b1;
            default:      nxt_busy   = 1'b1;
        endcase
    end

    always_comb begin
        own_score = ai_black ? black_best_score : white_best_score;
        own_y     = ai_black ? black_best_y     : white_best_y;
        own_x     = ai_black ? black_best_x     : white_best_x;
        opp_score = ai_black ? white_best_score : black_best_score;
        opp_y     = ai_black ? white_best_y     : black_best_y;
        opp_x     = ai_black ? white_best_x     : black_best_x;
        // One extra bit keeps the biased score from wrapping; ties go to attack.
        own_biased = {1'b0, own_score} + {1'b0, ATTACK_BIAS};
        attack     = own_biased >= {1'b0, opp_score};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            scan_cnt     <= 8'd0;
            ai_black     <= 1'b0;
            strat_clr    <= 1'b1;
            strat_active <= 1'b0;
            busy         <= 1'b0;
            move_valid   <= 1'b0;
            move_y       <= MID;
            move_x       <= MID;
            move_attack  <= 1'b0;
        end else begin
            state        <= next_state;
            strat_clr    <= nxt_clr;
            strat_active <= nxt_active;
            busy         <= nxt_busy;
            move_valid   <= nxt_valid;
            if (state == IDLE && start) begin
                ai_black <= ai_is_black;
            end
            if (state == SCAN && scan_cnt != SCAN_LAST) begin
                scan_cnt <= scan_cnt + 8'd1;
            end else begin
                scan_cnt <= 8'd0;
            end
            if (state == DECIDE) begin
                move_y      <= attack ? own_y : opp_y;
                move_x      <= attack ? own_x : opp_x;
                move_attack <= attack;
            end
        end
    end
endmodule

// File: tb/tb_gomoku_ai_ctrl.sv
// Directed bench for gomoku_ai_ctrl: default instance plus an ATTACK_BIAS=300 instance on shared inputs.
module tb_gomoku_ai_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        ai_is_black;
    logic [12:0] black_best_score;
    logic [3:0]  black_best_y;
    logic [3:0]  black_best_x;
    logic [12:0] white_best_score;
    logic [3:0]  white_best_y;
    logic [3:0]  white_best_x;

    logic        strat_clr, strat_active, strat_random, busy, move_valid, move_attack;
    logic [3:0]  move_y, move_x;
    logic        b_clr, b_active, b_random, b_busy, b_valid, b_attack;
    logic [3:0]  b_y, b_x;

    int vectors;
    int miscompares;

    gomoku_ai_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .ai_is_black      (ai_is_black),
        .black_best_score (black_best_score),
        .black_best_y     (black_best_y),
        .black_best_x     (black_best_x),
        .white_best_score (white_best_score),
        .white_best_y     (white_best_y),
        .white_best_x     (white_best_x),
        .strat_clr        (strat_clr),
        .strat_active     (strat_active),
        .strat_random     (strat_random),
        .busy             (busy),
        .move_valid       (move_valid),
        .move_y           (move_y),
        .move_x           (move_x),
        .move_attack      (move_attack)
    );

    gomoku_ai_ctrl #(.ATTACK_BIAS(13'd300)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .ai_is_black      (ai_is_black),
        .black_best_score (black_best_score),
        .black_best_y     (black_best_y),
        .black_best_x     (black_best_x),
        .white_best_score (white_best_score),
        .white_best_y     (white_best_y),
        .white_best_x     (white_best_x),
        .strat_clr        (b_clr),
        .strat_active     (b_active),
        .strat_random     (b_random),
        .busy             (b_busy),
        .move_valid       (b_valid),
        .move_y           (b_y),
        .move_x           (b_x),
        .move_attack      (b_attack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Cycle k below is the cycle after edge N+k, where N is the edge that samples start.
    task automatic run_move(input bit glitch,
                            input logic [3:0] ey, input logic [3:0] ex, input logic ea,
                            input logic [3:0] by, input logic [3:0] bx, input logic ba);
        int         act_cnt;
        int         mv_cnt;
        logic [3:0] prev_y;
        logic [3:0] prev_x;
        logic       prev_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_k0", busy, 1);
        chk("clr_k0", strat_clr, 1);
        chk("active_k0", strat_active, 0);
        prev_y  = move_y;
        prev_x  = move_x;
        prev_a  = move_attack;
        act_cnt = 0;
        mv_cnt  = 0;
        for (int k = 1; k <= 229; k++) begin
            tick();
            start = 1'b0;
            if (strat_active && k >= 2 && k <= 226) act_cnt++;
            if (move_valid) mv_cnt++;
            if (k == 1) begin
                chk("arm_clr", strat_clr, 0);
                chk("arm_active", strat_active, 0);
            end
            if (k == 227) begin
                chk("decide_valid", move_valid, 0);
                chk("decide_active", strat_active, 1);
                chk("move_held", {prev_y, prev_x, prev_a}, {move_y, move_x, move_attack});
            end
            if (k == 228) begin
                chk("done_valid", move_valid, 1);
                chk("move", {move_y, move_x, move_attack}, {ey, ex, ea});
                chk("move_bias", {b_y, b_x, b_attack}, {by, bx, ba});
            end
            if (k == 229) begin
                chk("idle_busy", busy, 0);
                chk("idle_active", strat_active, 1);
            end
            if (glitch && k == 52) begin
                start       = 1'b1;
                ai_is_black = ~ai_is_black;
            end
            if (glitch && k == 228) start = 1'b1;
        end
        chk("scan_active_cnt", act_cnt, 225);
        chk("valid_cnt", mv_cnt, 1);
    endtask

    initial begin
        int          lfsr_bad;
        int          mv_seen;
        int          busy_seen;
        logic [15:0] m;
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b0;
        start            = 1'b0;
        ai_is_black      = 1'b1;
        black_best_score = 13'd0;
        black_best_y     = 4'd0;
        black_best_x     = 4'd0;
        white_best_score = 13'd0;
        white_best_y     = 4'd0;
        white_best_x     = 4'd0;

        tick();
        tick();
        chk("rst_clr", strat_clr, 1);
        chk("rst_active", strat_active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_move", {move_y, move_x, move_attack}, {4'd7, 4'd7, 1'b0});
        chk("rst_lfsr", dut.u_lfsr.out, 16'hACE1);
        chk("rst_random", strat_random, 1);

        rst = 1'b1;
        tick();
        m = lfsr_next(16'hACE1);
        chk("first_idle_clr", strat_clr, 0);
        chk("first_idle_active", strat_active, 1);
        chk("first_idle_busy", busy, 0);
        chk("lfsr_step1", dut.u_lfsr.out, m);
        lfsr_bad = 0;
        for (int i = 2; i <= 65535; i++) begin
            tick();
            m = lfsr_next(m);
            if (strat_random !== m[0] || dut.u_lfsr.out === 16'h0000) lfsr_bad++;
        end
        chk("lfsr_seq_errors", lfsr_bad, 0);
        chk("lfsr_period", dut.u_lfsr.out, 16'hACE1);

        // AI black, opponent stronger: block; bias 300 turns it into a tie -> attack.
        ai_is_black = 1'b1;
        black_best_score = 13'd500; black_best_y = 4'd3; black_best_x = 4'd4;
        white_best_score = 13'd800; white_best_y = 4'd9; white_best_x = 4'd9;
        run_move(1'b0, 4'd9, 4'd9, 1'b0, 4'd3, 4'd4, 1'b1);

        // AI white, exact tie.
        ai_is_black = 1'b0;
        white_best_score = 13'd600; white_best_y = 4'd2; white_best_x = 4'd2;
        black_best_score = 13'd600; black_best_y = 4'd5; black_best_x = 4'd5;
        run_move(1'b0, 4'd2, 4'd2, 1'b1, 4'd2, 4'd2, 1'b1);

        // Near-full-scale own score plus bias must not wrap.
        ai_is_black = 1'b1;
        black_best_score = 13'd8191; black_best_y = 4'd1; black_best_x = 4'd2;
        white_best_score = 13'd8190; white_best_y = 4'd3; white_best_x = 4'd3;
        run_move(1'b0, 4'd1, 4'd2, 1'b1, 4'd1, 4'd2, 1'b1);

        ai_is_black = 1'b1;
        black_best_score = 13'd0;    black_best_y = 4'd0;  black_best_x = 4'd0;
        white_best_score = 13'd8191; white_best_y = 4'd14; white_best_x = 4'd14;
        run_move(1'b0, 4'd14, 4'd14, 1'b0, 4'd14, 4'd14, 1'b0);

        // Starts during SCAN (with colour flip) and in DONE are ignored.
        ai_is_black = 1'b1;
        black_best_score = 13'd500; black_best_y = 4'd3; black_best_x = 4'd4;
        white_best_score = 13'd800; white_best_y = 4'd9; white_best_x = 4'd9;
        run_move(1'b1, 4'd9, 4'd9, 1'b0, 4'd3, 4'd4, 1'b1);

        // Start in the first IDLE cycle after DONE is accepted, now as white.
        ai_is_black = 1'b0;
        run_move(1'b0, 4'd9, 4'd9, 1'b1, 4'd9, 4'd9, 1'b1);

        // Reset at SCAN cycle 100.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 102; k++) tick();
        chk("scan_active_pre_rst", strat_active, 1);
        rst = 1'b0;
        tick();
        chk("midrst_clr", strat_clr, 1);
        chk("midrst_active", strat_active, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", move_valid, 0);
        chk("midrst_move", {move_y, move_x, move_attack}, {4'd7, 4'd7, 1'b0});
        tick();
        rst = 1'b1;
        mv_seen   = 0;
        busy_seen = 0;
        for (int k = 0; k < 240; k++) begin
            tick();
            if (move_valid) mv_seen++;
            if (busy) busy_seen++;
        end
        chk("midrst_no_valid", mv_seen, 0);
        chk("midrst_no_busy", busy_seen, 0);

        ai_is_black = 1'b0;
        white_best_score = 13'd100; white_best_y = 4'd1;  white_best_x = 4'd1;
        black_best_score = 13'd101; black_best_y = 4'd12; black_best_x = 4'd13;
        run_move(1'b0, 4'd12, 4'd13, 1'b0, 4'd1, 4'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gomoku_ai_ctrl.md
GOMOKU_AI_CTRL -- requirements
Module: gomoku_ai_ctrl

Interface
REQ-001 The block SHALL have the parameters below, one per line: name, default, meaning.
- BOARD_SIZE, 15, board edge; the scan covers BOARD_SIZE*BOARD_SIZE cells.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
- ATTACK_BIAS, 13'd0, added to own score before the attack/defend compare.
REQ-002 The block SHALL have the ports below, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-low.
- start  in  1  one-cycle request to compute a move.
- ai_is_black  in  1  sampled at start; 1 = AI plays black.
- black_best_score  in  13  from the strategy block.
- black_best_y, black_best_x  in  4  from the strategy block.
- white_best_score  in  13  from the strategy block.
- white_best_y, white_best_x  in  4  from the strategy block.
- strat_clr  out  1  drives the strategy clr input.
- strat_active  out  1  drives the strategy active input.
- strat_random  out  1  drives the strategy random (tie-break) input.
- busy  out  1  high in every state except IDLE.
- move_valid  out  1  one-cycle pulse when a move is ready.
- move_y, move_x  out  4  chosen cell; held until the next move_valid.
- move_attack  out  1  1 = own best chosen, 0 = blocking move.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, ARM, SCAN, DECIDE, DONE.
REQ-004 IDLE: strat_clr=0, strat_active=1; start=1 SHALL latch ai_is_black and go to CLEAR.
REQ-005 CLEAR SHALL last 1 cycle with strat_clr=1, strat_active=0, then go to ARM.
REQ-006 ARM SHALL last 1 cycle with strat_clr=0, strat_active=0, then go to SCAN.
REQ-007 SCAN SHALL hold strat_active=1 for exactly BOARD_SIZE*BOARD_SIZE cycles (225), counted by an 8-bit scan_cnt running 0..224; at 224 it SHALL go to DECIDE.
REQ-008 DECIDE SHALL last 1 cycle with strat_active=1. It SHALL define own = AI-colour best and opp = other-colour best. If own_score+ATTACK_BIAS (14-bit, no overflow) >= opp_score, it SHALL register own y/x with move_attack=1; otherwise it SHALL register opp y/x with move_attack=0.
REQ-009 DONE SHALL assert move_valid=1 for exactly one cycle, then return to IDLE.
REQ-010 Latency: with start sampled at edge N, move_valid SHALL be high during the cycle after edge N+228.
REQ-011 start while busy=1 SHALL be ignored; it SHALL NOT be queued, and ai_is_black SHALL NOT be relatched.
REQ-012 start in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-013 Tie (own+bias == opp) SHALL resolve as attack.
REQ-014 strat_random SHALL be bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle, including IDLE.
REQ-015 move_y/move_x/move_attack SHALL change only in DECIDE.

Reset
REQ-016 On rst=0 at a clock edge, the block SHALL take these values: state=IDLE, scan_cnt=0, lfsr=LFSR_SEED, strat_clr=1, strat_active=0, busy=0, move_valid=0, move_y=move_x=BOARD_SIZE/2 (7), move_attack=0.
REQ-017 Reset asserted mid-SCAN SHALL abort the scan with no move_valid; the next start SHALL perform a full CLEAR/ARM/SCAN.
REQ-018 After reset is released, the first IDLE cycle SHALL drive strat_clr=0, strat_active=1.

Structure
REQ-019 BOARD_SIZE, the state encoding, the score width (13) and the coordinate width (4) SHALL live in shared package gomoku_pkg.
REQ-020 The LFSR SHALL be a sub-module gomoku_lfsr (clk, rst, seed, out); everything else SHALL be flat.

Verification
REQ-021 Bench (with the real strategy block and an empty board): reset, then start at edge 10 -> busy=1 from edge 10; move_valid pulses after edge 238; total SCAN strat_active high count = 225.
REQ-022 Forced inputs in DECIDE, AI black: black=(500,3,4), white=(800,9,9) -> move=(9,9), move_attack=0; with ATTACK_BIAS=300 -> move=(3,4), move_attack=1.
REQ-023 Tie: AI white, white=(600,2,2), black=(600,5,5) -> move=(2,2), move_attack=1.
REQ-024 start pulses at SCAN cycle 50 and in the DONE cycle -> ignored; exactly one move_valid; a start one cycle after DONE -> accepted.
REQ-025 rst=0 at SCAN cycle 100 -> move_valid never pulses, move=(7,7), strat_clr=1 during reset; the next start produces a full 228-cycle sequence.
REQ-026 LFSR: after reset, 65535 cycles -> the sequence repeats with period 65535 and never reaches 0.
